// File: rtl/aes_inv_seq.sv
// ---------------------------------------------------------------------------
// aes_inv_seq
//
// Host-side sequencer for the AES decryption core (aes_inv_cipher_top).
// It latches a ciphertext/key pair, pulses the core's key-expansion load and
// then its data load, and waits for the core to finish. When the core is done
// it registers the plaintext and returns a one-cycle completion pulse. The
// block also reports requests that arrive while busy, and it flags a core
// that hangs past RUN_MAX cycles.
//
// Optional feature: `AES_INV_KEY_CACHE_EN
//   When this macro is defined, a repeat request with the key already held in
//   core_key skips key expansion. The cached key is valid only after a
//   completed KEXP phase. A timeout or a reset invalidates it.
//
// Parameters
//   KEXP_CYCLES : cycles the core needs after core_kld before core_ld (>= 1)
//   RUN_MAX     : cycles to wait for core_done after core_ld (1..255)
//
// Ports
//   clk           in   : clock; all logic on the rising edge
//   rst           in   : synchronous active-low reset
//   ld            in   : start request
//   key           in   : 128-bit decryption key, sampled with ld
//   text_in       in   : 128-bit ciphertext, sampled with ld
//   text_out      out  : 128-bit plaintext, held until the next completion
//   done          out  : one-cycle completion pulse
//   busy          out  : high while not IDLE
//   ld_drop       out  : one-cycle pulse for an ld ignored while busy
//   err           out  : one-cycle pulse on core timeout
//   core_kld      out  : key-expansion load pulse to the core
//   core_ld       out  : data load pulse to the core
//   core_key      out  : registered key to the core
//   core_text_in  out  : registered ciphertext to the core
//   core_text_out in   : core plaintext result
//   core_done     in   : core completion (level or pulse)
// ---------------------------------------------------------------------------
module aes_inv_seq #(
    parameter int KEXP_CYCLES = 10,
    parameter int RUN_MAX     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic [127:0] text_out,
    output logic         done,
    output logic         busy,
    output logic         ld_drop,
    output logic         err,
    output logic         core_kld,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic [127:0] core_text_out,
    input  logic         core_done
);

    localparam int KCW = (KEXP_CYCLES > 1) ? $clog2(KEXP_CYCLES) : 1;
    localparam logic [KCW-1:0] K_LAST = KCW'(KEXP_CYCLES - 1);
    localparam logic [7:0]     R_LAST = 8'(RUN_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEXP,
        S_LOAD,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [KCW-1:0]  r_kcnt;
    logic [7:0]      r_rcnt;
    logic [127:0]    r_text_out;
    logic [127:0]    r_core_key;
    logic [127:0]    r_core_text_in;
    logic            r_done;
    logic            r_busy;
    logic            r_ld_drop;
    logic            r_err;
    logic            r_core_kld;
    logic            r_core_ld;
    logic            w_hit;

`ifdef AES_INV_KEY_CACHE_EN
    logic            r_kvalid;
    // A request may reuse the expanded key only when the held key is the same
    // one that last went through a complete KEXP phase.
    assign w_hit = r_kvalid && (key == r_core_key);
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the wide data registers are reset too, because text_out and
            // core_* are visible outputs that must read 0 after reset.
            r_state        <= S_IDLE;
            r_kcnt         <= '0;
            r_rcnt         <= '0;
            r_text_out     <= '0;
            r_core_key     <= '0;
            r_core_text_in <= '0;
            r_done         <= 1'b0;
            r_busy         <= 1'b0;
            r_ld_drop      <= 1'b0;
            r_err          <= 1'b0;
            r_core_kld     <= 1'b0;
            r_core_ld      <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
            r_kvalid       <= 1'b0;
`endif
        end else begin
            // NOTE: every pulse output defaults low here. A branch that needs a
            // pulse overrides it, so no pulse lasts more than one cycle.
            // Non-blocking assignments keep every branch reading pre-edge state.
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ld_drop  <= 1'b0;
            r_core_kld <= 1'b0;
            r_core_ld  <= 1'b0;

            if (ld && (r_state != S_IDLE))
                r_ld_drop <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (ld) begin
                        r_core_key     <= key;
                        r_core_text_in <= text_in;
                        r_busy         <= 1'b1;
                        if (w_hit) begin
                            r_state   <= S_LOAD;
                            r_core_ld <= 1'b1;
                        end else begin
                            r_state    <= S_KEXP;
                            r_core_kld <= 1'b1;
                            r_kcnt     <= '0;
                        end
                    end
                end
                S_KEXP: begin
                    if (r_kcnt == K_LAST) begin
                        // core_ld is raised on entry, so it is high for the
                        // single LOAD cycle.
                        r_state   <= S_LOAD;
                        r_core_ld <= 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
                        r_kvalid  <= 1'b1;
`endif
                    end else begin
                        r_kcnt <= r_kcnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                    r_rcnt  <= '0;
                end
                S_RUN: begin
                    // done takes priority over the timeout on the last cycle
                    if (core_done) begin
                        r_text_out <= core_text_out;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_rcnt == R_LAST) begin
                        r_err      <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
`ifdef AES_INV_KEY_CACHE_EN
                        r_kvalid   <= 1'b0;
`endif
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign text_out     = r_text_out;
    assign done         = r_done;
    assign busy         = r_busy;
    assign ld_drop      = r_ld_drop;
    assign err          = r_err;
    assign core_kld     = r_core_kld;
    assign core_ld      = r_core_ld;
    assign core_key     = r_core_key;
    assign core_text_in = r_core_text_in;

endmodule

// File: tb/tb_aes_inv_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_seq
//
// Directed bench for aes_inv_seq. A small behavioural core model returns a
// chosen plaintext a fixed number of cycles after core_ld, or it never
// returns. Cycle numbering: the edge that samples ld is cycle 0. The value
// observed 1 ns after edge n-1 is the value that edge n samples, so that
// value is called "cycle n".
// ---------------------------------------------------------------------------
module tb_aes_inv_seq;

    localparam int KEXP = 10;
    localparam int RMAX = 16;

`ifdef AES_INV_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C3 = 128'hcafef00dcafef00dcafef00dcafef00d;
    localparam logic [127:0] JUNK = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] text_in = '0;
    logic [127:0] text_out;
    logic         done, busy, ld_drop, err, core_kld, core_ld;
    logic [127:0] core_key, core_text_in, core_text_out;
    logic         core_done;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    aes_inv_seq #(.KEXP_CYCLES(KEXP), .RUN_MAX(RMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld           (ld),
        .key          (key),
        .text_in      (text_in),
        .text_out     (text_out),
        .done         (done),
        .busy         (busy),
        .ld_drop      (ld_drop),
        .err          (err),
        .core_kld     (core_kld),
        .core_ld      (core_ld),
        .core_key     (core_key),
        .core_text_in (core_text_in),
        .core_text_out(core_text_out),
        .core_done    (core_done)
    );

    always #5 clk = ~clk;

    // Core model: core_done is sampled high exactly core_lat edges after the
    // edge that sampled core_ld. core_lat == 0 models a hung core.
    int           core_lat = 12;
    logic [127:0] core_pt = '0;
    int           m_cnt = 0;
    bit           m_act = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_act <= 1'b0;
            m_cnt <= 0;
        end else if (core_ld) begin
            m_act <= 1'b1;
            m_cnt <= 1;
        end else if (m_act) begin
            m_cnt <= m_cnt + 1;
            if (core_done) m_act <= 1'b0;
        end
    end

    assign core_done     = m_act && (core_lat != 0) && (m_cnt == core_lat);
    assign core_text_out = core_done ? core_pt : JUNK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request that is sampled by the next edge (cycle 0).
    task automatic start_ld(input logic [127:0] k, input logic [127:0] c);
        key     = k;
        text_in = c;
        ld      = 1'b1;
        tick();
        ld      = 1'b0;
        check("accept_no_drop", ld_drop, 1'b0);
    endtask

    // Follow one operation from cycle 1 to its done/err cycle. The task
    // returns in that cycle without advancing, so the caller can issue the
    // next ld there. exp_pt is the plaintext expected after a done; after a
    // timeout it is the value text_out must keep.
    task automatic follow(input bit hit, input bit tmo, input logic [127:0] exp_pt,
                          input logic [127:0] exp_key, input logic [127:0] exp_ct,
                          input bit drops);
        int l_cyc;
        int end_c;
        l_cyc = hit ? 1 : KEXP + 1;
        end_c = tmo ? l_cyc + RMAX + 1 : l_cyc + core_lat + 1;
        for (int n = 1; n <= end_c; n++) begin
            check($sformatf("kld@%0d", n), core_kld, (!hit && n == 1));
            check($sformatf("core_ld@%0d", n), core_ld, (n == l_cyc));
            check($sformatf("busy@%0d", n), busy, (n < end_c));
            check($sformatf("done@%0d", n), done, (!tmo && n == end_c));
            check($sformatf("err@%0d", n), err, (tmo && n == end_c));
            check($sformatf("core_key@%0d", n), core_key, exp_key);
            check($sformatf("core_text_in@%0d", n), core_text_in, exp_ct);
            if (drops) check($sformatf("ld_drop@%0d", n), ld_drop, (n == 4 || n == 8));
            if (n == end_c) begin
                check(tmo ? "text_out_kept" : "text_out", text_out, exp_pt);
            end else begin
                if (drops && (n == 3 || n == 7)) begin
                    key     = ~exp_key;
                    text_in = ~exp_ct;
                    ld      = 1'b1;
                end
                tick();
                ld = 1'b0;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_text_out"}, text_out, '0);
        check({tag, "_core_key"}, core_key, '0);
        check({tag, "_core_text_in"}, core_text_in, '0);
        check({tag, "_ctl"}, {done, busy, ld_drop, err, core_kld, core_ld}, 6'b0);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Full path: kld at 1, core_ld at 11, done at 24
        core_lat = 12;
        core_pt  = P1;
        start_ld(K1, C1);
        follow(1'b0, 1'b0, P1, K1, C1, 1'b0);

        // Same key issued in the done cycle, dropped requests at cycles 3 and 7
        core_pt = P2;
        start_ld(K1, C2);
        follow(CACHE, 1'b0, P2, K1, C2, 1'b1);

        // Hung core: err at core_ld + RMAX + 1, and text_out keeps P2
        core_lat = 0;
        start_ld(K1, C3);
        follow(CACHE, 1'b1, P2, K1, C3, 1'b0);

        // The timeout invalidated the cache, so a same-key ld in the err cycle
        // goes through KEXP
        core_lat = 12;
        core_pt  = P1;
        start_ld(K1, C1);
        follow(1'b0, 1'b0, P1, K1, C1, 1'b0);

        // Reset during RUN abandons the operation silently
        start_ld(K2, C2);
        for (int i = 0; i < KEXP + 2; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_all_zero("rst_mid");
        tick();
        check("rst_mid_quiet", {done, err, busy}, 3'b0);

        // After reset the cache is invalid, so this op runs KEXP and completes
        core_pt = P2;
        start_ld(K2, C2);
        follow(1'b0, 1'b0, P2, K2, C2, 1'b0);

        // core_done arrives on the last timeout cycle: done wins, no err
        core_lat = RMAX;
        core_pt  = P1;
        start_ld(K2, C1);
        follow(CACHE, 1'b0, P1, K2, C1, 1'b0);
        tick();
        check("done_single_cycle", {done, err}, 2'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
